// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: applies AND/OR/XOR/NOR to latched operands
// one SLICE-bit chunk per clock and publishes the full result with a done pulse.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_done;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_slice_res;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    // Only the selected slice passes through the gate array each cycle.
    always_comb begin
        w_a_slice   = r_a[r_idx*SLICE +: SLICE];
        w_b_slice   = r_b[r_idx*SLICE +: SLICE];
        w_slice_res = '0;
        case (r_op)
            2'b00:   w_slice_res = w_a_slice & w_b_slice;
            2'b01:   w_slice_res = w_a_slice | w_b_slice;
            2'b10:   w_slice_res = w_a_slice ^ w_b_slice;
            default: w_slice_res = ~(w_a_slice | w_b_slice);
        endcase
        w_acc_next = r_acc;
        w_acc_next[r_idx*SLICE +: SLICE] = w_slice_res;
    end

    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_out  <= '0;
            r_zero <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    // out/zero are only ever written with the complete result.
                    if (w_last) begin
                        r_out  <= w_acc_next;
                        r_zero <= (w_acc_next == '0);
                        r_done <= 1'b1;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = r_done;
    assign out  = r_out;
    assign zero = r_zero;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Bench for seq_logic_unit: directed scenarios on a 32/8 instance plus random
// sweeps on 32/32 and 64/16 instances, checked through expected-result queues.
module tb_seq_logic_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start0, busy0, done0, zero0;
    logic [1:0]  op0;
    logic [31:0] a0, b0, out0;

    logic        start1, busy1, done1, zero1;
    logic [1:0]  op1;
    logic [31:0] a1, b1, out1;

    logic        start2, busy2, done2, zero2;
    logic [1:0]  op2;
    logic [63:0] a2, b2, out2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp1_q[$];
    logic [63:0] exp2_q[$];

    seq_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .out(out0), .zero(zero0)
    );

    seq_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .out(out1), .zero(zero1)
    );

    seq_logic_unit #(.WIDTH(64), .SLICE(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .out(out2), .zero(zero2)
    );

    function automatic logic [31:0] ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Called at a falling edge; leaves the bench at the falling edge after the start edge.
    task automatic issue0(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start0 = 1'b1;
        op0    = o;
        a0     = x;
        b0     = y;
        exp_q.push_back(ref32(o, x, y));
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // cycles = falling edges until done seen (0 on timeout); held = out/zero/busy steady before done.
    task automatic wait_done0(output int cycles, output bit held);
        logic [31:0] prev_out;
        logic        prev_zero;
        prev_out  = out0;
        prev_zero = zero0;
        held      = 1'b1;
        cycles    = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done0) begin
                cycles = c;
                break;
            end
            if (out0 !== prev_out || zero0 !== prev_zero || busy0 !== 1'b1) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
        start1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
        start2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done0); end
        n_vec++; if (out0 !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected 00000000", out0); end
        n_vec++; if (zero0 !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", zero0); end
        n_vec++; if (out2 !== 64'h0 || zero2 !== 1'b1) begin n_err++; $display("FAIL reset_w64: got %h/%b expected 0/1", out2, zero2); end
    endtask

    task automatic test_xor();
        int          cyc;
        bit          held;
        logic [31:0] e;
        issue0(2'b10, 32'hF0F01234, 32'h0FF0FFFF);
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL xor_busy_rise: got %b expected 1", busy0); end
        wait_done0(cyc, held);
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL xor_latency: got %0d expected 4", cyc); end
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL xor_held: got %b expected 1", held); end
        e = exp_q.pop_front();
        n_vec++; if (out0 !== e) begin n_err++; $display("FAIL xor_out: got %h expected %h", out0, e); end
        n_vec++; if (out0 !== 32'hFF00EDCB) begin n_err++; $display("FAIL xor_out_lit: got %h expected ff00edcb", out0); end
        n_vec++; if (zero0 !== 1'b0) begin n_err++; $display("FAIL xor_zero: got %b expected 0", zero0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL xor_busy_fall: got %b expected 0", busy0); end
        @(negedge clk);
        n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL xor_done_pulse: got %b expected 0", done0); end
    endtask

    task automatic test_ops();
        logic [1:0]  t_op[3];
        logic [31:0] t_a[3];
        logic [31:0] t_b[3];
        int          cyc;
        bit          held;
        logic [31:0] e;
        t_op[0] = 2'b00; t_a[0] = 32'hAAAAAAAA; t_b[0] = 32'h55555555;
        t_op[1] = 2'b11; t_a[1] = 32'h00000000; t_b[1] = 32'h00000000;
        t_op[2] = 2'b01; t_a[2] = 32'h0000FFFF; t_b[2] = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            issue0(t_op[i], t_a[i], t_b[i]);
            wait_done0(cyc, held);
            n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL ops%0d_latency: got %0d expected 4", i, cyc); end
            n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL ops%0d_held: got %b expected 1", i, held); end
            e = exp_q.pop_front();
            n_vec++; if (out0 !== e) begin n_err++; $display("FAIL ops%0d_out: got %h expected %h", i, out0, e); end
            n_vec++; if (zero0 !== (e == 32'h0)) begin n_err++; $display("FAIL ops%0d_zero: got %b expected %b", i, zero0, (e == 32'h0)); end
            @(negedge clk);
        end
    endtask

    task automatic test_isolation();
        int          cyc;
        int          extra;
        logic [31:0] e;
        start0 = 1'b1; op0 = 2'b10; a0 = 32'h12345678; b0 = 32'h0;
        exp_q.push_back(ref32(2'b10, 32'h12345678, 32'h0));
        @(negedge clk);
        a0 = 32'h0; b0 = 32'hFFFF0000; op0 = 2'b00;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done0) begin
                cyc    = c;
                start0 = 1'b0;
                break;
            end
        end
        start0 = 1'b0;
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL iso_latency: got %0d expected 4", cyc); end
        e = exp_q.pop_front();
        n_vec++; if (out0 !== e) begin n_err++; $display("FAIL iso_out: got %h expected %h", out0, e); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL iso_extra_done: got %0d expected 0", extra); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL iso_busy: got %b expected 0", busy0); end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        bit          held;
        logic [31:0] e;
        issue0(2'b01, 32'h0F0F0F0F, 32'h0);
        wait_done0(cyc, held);
        e = exp_q.pop_front();
        n_vec++; if (out0 !== e) begin n_err++; $display("FAIL b2b_first_out: got %h expected %h", out0, e); end
        issue0(2'b00, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_done0(cyc, held);
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL b2b_prior_held: got %b expected 1", held); end
        e = exp_q.pop_front();
        n_vec++; if (out0 !== e) begin n_err++; $display("FAIL b2b_out: got %h expected %h", out0, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int          cyc;
        int          extra;
        bit          held;
        logic [31:0] e;
        issue0(2'b10, 32'hFFFF0000, 32'h00000001);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy0); end
        n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", done0); end
        n_vec++; if (out0 !== 32'h0) begin n_err++; $display("FAIL rst_mid_out: got %h expected 00000000", out0); end
        n_vec++; if (zero0 !== 1'b1) begin n_err++; $display("FAIL rst_mid_zero: got %b expected 1", zero0); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d expected 0", extra); end
        issue0(2'b01, 32'h00000001, 32'h80000000);
        wait_done0(cyc, held);
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL rst_fresh_latency: got %0d expected 4", cyc); end
        e = exp_q.pop_front();
        n_vec++; if (out0 !== e) begin n_err++; $display("FAIL rst_fresh_out: got %h expected %h", out0, e); end
        @(negedge clk);
    endtask

    task automatic test_sweep_n1();
        int          cyc;
        logic [1:0]  o;
        logic [31:0] x, y, e;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(3, 0));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(7, 0) == 0) y = x;
            if ($urandom_range(15, 0) == 0) begin x = '0; y = '0; end
            start1 = 1'b1; op1 = o; a1 = x; b1 = y;
            exp1_q.push_back(ref32(o, x, y));
            @(negedge clk);
            start1 = 1'b0;
            cyc = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (done1) begin cyc = c; break; end
            end
            e = exp1_q.pop_front();
            n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL n1_latency[%0d]: got %0d expected 1", i, cyc); end
            n_vec++; if (out1 !== e) begin n_err++; $display("FAIL n1_out[%0d]: got %h expected %h", i, out1, e); end
            n_vec++; if (zero1 !== (e == 32'h0)) begin n_err++; $display("FAIL n1_zero[%0d]: got %b expected %b", i, zero1, (e == 32'h0)); end
            repeat ($urandom_range(1, 0)) @(negedge clk);
        end
    endtask

    task automatic test_sweep_w64();
        int          cyc;
        logic [1:0]  o;
        logic [63:0] x, y, e;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(3, 0));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if ($urandom_range(7, 0) == 0) y = x;
            if ($urandom_range(15, 0) == 0) begin x = '0; y = '0; end
            start2 = 1'b1; op2 = o; a2 = x; b2 = y;
            exp2_q.push_back(ref64(o, x, y));
            @(negedge clk);
            start2 = 1'b0;
            if ($urandom_range(1, 0) == 1) begin
                a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; op2 = 2'($urandom_range(3, 0));
            end
            cyc = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (done2) begin cyc = c; break; end
            end
            e = exp2_q.pop_front();
            n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL w64_latency[%0d]: got %0d expected 4", i, cyc); end
            n_vec++; if (out2 !== e) begin n_err++; $display("FAIL w64_out[%0d]: got %h expected %h", i, out2, e); end
            n_vec++; if (zero2 !== (e == 64'h0)) begin n_err++; $display("FAIL w64_zero[%0d]: got %b expected %b", i, zero2, (e == 64'h0)); end
            repeat ($urandom_range(1, 0)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_ops();
        test_isolation();
        test_back_to_back();
        test_reset_mid();
        test_sweep_n1();
        test_sweep_w64();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
